// File: rtl/divider.sv
// divider: multicycle signed WIDTH-bit integer divider for the DIV instruction.
// Restoring division on operand magnitudes, one quotient bit per clock, then a
// single sign fix-up cycle.  Quotient goes to lo, remainder to hi.
// Optional build macro: DIVIDER_ZERO_CHECK_EN -- when defined, a zero divisor
// finishes after one cycle with div_zero=1 and hi/lo left untouched.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             finished,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_ZERO = 2'd3
   } state_t;

   // Two's-complement negate when neg is set, pass through otherwise.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
      logic [WIDTH-1:0] r;
      if (neg) begin
         r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic             negq_q, negq_d;   // quotient must be negated
   logic             negr_q, negr_d;   // remainder must be negated
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             fin_q, fin_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] trial_s;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= {WIDTH{1'b0}};
         quo_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next-state logic: launch, one restoring step per cycle, sign fix-up.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      fin_d   = 1'b0;
      dz_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      trial_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

      case (state_q)
         S_IDLE: begin
            if (div_start) begin
               quo_d  = cond_neg(dividend, dividend[WIDTH-1]);
               dvs_d  = cond_neg(divisor, divisor[WIDTH-1]);
               negr_d = dividend[WIDTH-1];
               negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rem_d  = {WIDTH{1'b0}};
               cnt_d  = {CW{1'b0}};
               busy_d = 1'b1;
`ifdef DIVIDER_ZERO_CHECK_EN
               if (divisor == {WIDTH{1'b0}}) begin
                  state_d = S_ZERO;
               end else begin
                  state_d = S_RUN;
               end
`else
               state_d = S_RUN;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // A zero divisor always subtracts, giving an all-ones quotient.
            if (trial_s >= dvs_q) begin
               rem_d = trial_s - dvs_q;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial_s;
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_CNT) begin
               state_d = S_FIX;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FIX: begin
            lo_d    = cond_neg(quo_q, negq_q);
            hi_d    = cond_neg(rem_q, negr_q);
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ZERO: begin
            // Zero divisor short-cut: results untouched, flag the condition.
`ifdef DIVIDER_ZERO_CHECK_EN
            fin_d = 1'b1;
            dz_d  = 1'b1;
`endif
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = busy_q;
   assign finished = fin_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
`ifdef DIVIDER_ZERO_CHECK_EN
   assign div_zero = dz_q;
`else
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for the multicycle signed divider.
module tb_divider;

   logic        clock;
   logic        reset;
   logic        div_start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        finished;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int total    = 0;
   int bad      = 0;
   int exp_fin  = 0;
   int fin_seen = 0;

   divider #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .div_start(div_start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .finished (finished),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count every cycle in which finished is high.
   always @(posedge clock) begin
      if (finished === 1'b1) fin_seen <= fin_seen + 1;
   end

   // Reference: signed division truncating toward zero, remainder follows dividend.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   // Launch a division at a negedge and wait for finished; returns at the
   // negedge after the finished-raising edge.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok);
      busy_ok   = 1'b1;
      lat       = 0;
      div_start = 1'b1;
      dividend  = a;
      divisor   = b;
      @(posedge clock);
      @(negedge clock);
      div_start = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      exp_fin++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      while (lat < 100) begin
         @(posedge clock);
         @(negedge clock);
         lat++;
         if (finished === 1'b1) begin
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end else if (busy !== 1'b1) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      div_start = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (finished !== 1'b0) begin bad++; $display("FAIL reset_finished: got %b want 0", finished); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_positive();
      int lat;
      bit bok;
      do_div(32'd7, 32'd2, lat, bok);
      total++; if (lat != 33) begin bad++; $display("FAIL pos_latency: got %0d want 33", lat); end
      total++; if (!bok) begin bad++; $display("FAIL pos_busy: busy profile wrong got 0 want 1"); end
      total++; if (lo !== 32'd3) begin bad++; $display("FAIL pos_lo: got %h want 3", lo); end
      total++; if (hi !== 32'd1) begin bad++; $display("FAIL pos_hi: got %h want 1", hi); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL pos_div_zero: got %b want 0", div_zero); end
      @(negedge clock);
      total++; if (finished !== 1'b0) begin bad++; $display("FAIL pos_pulse_width: got %b want 0", finished); end
      total++; if ({hi, lo} !== {32'd1, 32'd3}) begin bad++; $display("FAIL pos_hold: got %h want 0000000100000003", {hi, lo}); end
   endtask

   task automatic test_signs();
      logic [31:0] tv [7][4];
      int lat;
      bit bok;
      tv[0] = '{32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
      tv[1] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
      tv[2] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
      tv[3] = '{32'd2000000007, 32'hA697_D0FF, 32'hFFFF_FFFF, 32'd500000006};
      tv[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      tv[5] = '{32'd100,       32'd7,         32'd14,        32'd2};
      tv[6] = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0};
      for (int i = 0; i < 7; i++) begin
         do_div(tv[i][0], tv[i][1], lat, bok);
         total++; if (lat != 33 || !bok) begin bad++; $display("FAIL sign_timing[%0d]: got lat=%0d busy_ok=%0d want 33/1", i, lat, bok); end
         total++; if (lo !== tv[i][2]) begin bad++; $display("FAIL sign_lo[%0d]: got %h want %h", i, lo, tv[i][2]); end
         total++; if (hi !== tv[i][3]) begin bad++; $display("FAIL sign_hi[%0d]: got %h want %h", i, hi, tv[i][3]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, eq, er;
      int lat;
      bit bok;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case (i % 3)
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 15));
            default: b = -32'($urandom_range(1, 300));
         endcase
`ifdef DIVIDER_ZERO_CHECK_EN
         if (b == 32'd0) b = 32'd3;
`endif
         ref_div(a, b, eq, er);
         do_div(a, b, lat, bok);
         total++; if (lat != 33 || !bok) begin bad++; $display("FAIL rand_timing[%0d]: got lat=%0d busy_ok=%0d want 33/1", i, lat, bok); end
         total++; if ({hi, lo} !== {er, eq}) begin bad++; $display("FAIL rand_result[%0d] %h/%h: got hi=%h lo=%h want hi=%h lo=%h", i, a, b, hi, lo, er, eq); end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      div_start = 1'b1;
      dividend  = 32'd100;
      divisor   = 32'd7;
      @(posedge clock);
      @(negedge clock);
      div_start = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      exp_fin++;
      repeat (4) begin
         @(posedge clock);
         @(negedge clock);
      end
      div_start = 1'b1;
      dividend  = 32'd50;
      divisor   = 32'd5;
      @(posedge clock);
      @(negedge clock);
      div_start = 1'b0;
      lat = 5;
      while (lat < 100 && finished !== 1'b1) begin
         @(posedge clock);
         @(negedge clock);
         lat++;
      end
      total++; if (lat != 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", lat); end
      total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL ignore_result: got hi=%h lo=%h want hi=2 lo=e", hi, lo); end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [31:0] eq, er;
      int lat;
      bit bok;
      do_div(32'd1000, 32'd33, lat, bok);
      total++; if ({hi, lo} !== {32'd10, 32'd30}) begin bad++; $display("FAIL b2b_first: got hi=%h lo=%h want hi=a lo=1e", hi, lo); end
      ref_div(-32'd1000, 32'd7, eq, er);
      do_div(-32'd1000, 32'd7, lat, bok);
      total++; if (lat != 33 || !bok) begin bad++; $display("FAIL b2b_timing: got lat=%0d busy_ok=%0d want 33/1", lat, bok); end
      total++; if ({hi, lo} !== {er, eq}) begin bad++; $display("FAIL b2b_second: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, er, eq); end
   endtask

   task automatic test_reset_mid();
      int spurious;
      int lat;
      bit bok;
      spurious  = 0;
      div_start = 1'b1;
      dividend  = 32'd100;
      divisor   = 32'd7;
      @(posedge clock);
      @(negedge clock);
      div_start = 1'b0;
      repeat (9) begin
         @(posedge clock);
         @(negedge clock);
      end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      total++; if ({busy, finished, div_zero, hi, lo} !== 67'd0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", {busy, finished, div_zero, hi, lo}); end
      reset = 1'b0;
      repeat (40) begin
         @(posedge clock);
         @(negedge clock);
         if (finished !== 1'b0 || busy !== 1'b0) spurious++;
      end
      total++; if (spurious != 0) begin bad++; $display("FAIL midreset_quiet: got %0d active cycles want 0", spurious); end
      do_div(32'd9, 32'd3, lat, bok);
      total++; if (lat != 33 || {hi, lo} !== {32'd0, 32'd3}) begin bad++; $display("FAIL midreset_after: got lat=%0d hi=%h lo=%h want 33 0 3", lat, hi, lo); end
   endtask

   task automatic test_div_zero();
      int lat;
      bit bok;
      do_div(32'd9, 32'd3, lat, bok);
`ifdef DIVIDER_ZERO_CHECK_EN
      do_div(32'd5, 32'd0, lat, bok);
      total++; if (lat != 1 || !bok) begin bad++; $display("FAIL dz_timing: got lat=%0d busy_ok=%0d want 1/1", lat, bok); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_zero); end
      total++; if ({hi, lo} !== {32'd0, 32'd3}) begin bad++; $display("FAIL dz_hold: got hi=%h lo=%h want hi=0 lo=3", hi, lo); end
      @(negedge clock);
      total++; if ({finished, div_zero} !== 2'b00) begin bad++; $display("FAIL dz_clear: got %b want 00", {finished, div_zero}); end
`else
      do_div(32'd5, 32'd0, lat, bok);
      total++; if (lat != 33 || !bok) begin bad++; $display("FAIL dz_timing: got lat=%0d busy_ok=%0d want 33/1", lat, bok); end
      total++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL dz_result: got hi=%h lo=%h want hi=5 lo=ffffffff", hi, lo); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_flag: got %b want 0", div_zero); end
`endif
   endtask

   initial begin
      test_reset();
      test_positive();
      test_signs();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_div_zero();
      repeat (3) @(negedge clock);
      total++; if (fin_seen != exp_fin) begin bad++; $display("FAIL finished_count: got %0d want %0d", fin_seen, exp_fin); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Multicycle signed 32-bit integer divider for the MIPS datapath's DIV instruction, the inverse counterpart of the multicycle multiplier. It uses a start/finished handshake and writes quotient to `lo` and remainder to `hi`. It sits beside the multiplier, and the control unit stalls on it until `finished` pulses.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `div_start`  in  1: sampled only in IDLE; launches a division.
- `dividend`  in  WIDTH: two's-complement dividend, sampled with `div_start`.
- `divisor`  in  WIDTH: two's-complement divisor, sampled with `div_start`.
- `busy`  out  1: high while a division is in progress.
- `finished`  out  1: one-cycle pulse when `hi`/`lo` are updated.
- `div_zero`  out  1: divide-by-zero flag, valid with `finished` (see Configuration).
- `hi`  out  WIDTH: remainder.
- `lo`  out  WIDTH: quotient.

## Operation
- Algorithm is restoring division on magnitudes, then sign fix-up.
  - Quotient is truncated toward zero.
  - Remainder takes the dividend's sign.
  - The identity dividend = lo*divisor + hi holds (mod 2^WIDTH).
- States:
  - IDLE: `busy`=0.
    - `div_start`=1 at an edge: latch |dividend|, |divisor|, sign(dividend), and sign(dividend)^sign(divisor).
    - Clear the partial remainder, set count=0, go to RUN.
  - RUN: one quotient bit per edge.
    - Partial remainder R = {R[WIDTH-2:0], next dividend MSB}.
    - If R >= |divisor|: R -= |divisor| and the quotient bit is 1; otherwise the bit is 0.
    - After WIDTH iterations go to FIX.
  - FIX: on one edge, negate the quotient and/or remainder per the latched signs, write `lo`/`hi`, set `finished`=1, go to IDLE.
- Arithmetic is WIDTH-bit modular. -2^31 / -1 yields `lo`=0x80000000, `hi`=0 with no overflow flag.
- `div_start` while `busy` is ignored, and the operands are not re-sampled.
- Operand inputs may change freely after the sampling edge.
- `hi`/`lo` hold their value until the next FIX write or reset.
- Reset mid-operation: the division is abandoned and the block returns to IDLE. No `finished` is produced.

## Timing
- Reset values: `busy`=0, `finished`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE.
- Let edge 0 be the edge that samples `div_start`.
  - `busy`=1 from edge 0 through edge WIDTH+1.
  - `finished`=1 for exactly one cycle after edge WIDTH+1 (edge 33 for WIDTH=32).
  - `hi`/`lo` are valid from that same edge.
- `busy` falls on the same edge that `finished` rises.
- Back-to-back operation: `div_start` sampled on the edge after `finished` rose (edge WIDTH+2) is accepted.
- `finished` never asserts without a preceding accepted `div_start`.

## Configuration
- Macro: `DIVIDER_ZERO_CHECK_EN`.
- Defined:
  - A divisor of 0 at edge 0 skips RUN/FIX.
  - At edge 1: `finished`=1, `div_zero`=1, `busy`=0, and `hi`/`lo` are unchanged.
  - `div_zero` clears on the next edge and is 0 for all nonzero-divisor results.
- Undefined:
  - `div_zero` is tied to 0.
  - A zero divisor runs the full WIDTH+1-cycle algorithm deterministically.
  - Magnitude quotient is all ones and magnitude remainder is |dividend|, then the sign fix-up is applied. Example: 7/0 gives `lo`=0xFFFFFFFF, `hi`=7.

## Test plan
- Positive operands: reset, then 7 / 2 → `lo`=3, `hi`=1; `finished` pulses exactly once, 33 edges after the start edge; `busy` high in between.
- Sign combinations:
  - -7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 7/-2 → `lo`=0xFFFFFFFD, `hi`=1.
  - -7/-2 → `lo`=3, `hi`=0xFFFFFFFF.
- Large operands and overflow:
  - 2000000007 / -1500000001 → `lo`=0xFFFFFFFF, `hi`=500000006.
  - 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Handshake:
  - Pulse `div_start` with new operands at cycle 5 of a running 100/7 → ignored; result `lo`=14, `hi`=2.
  - A start on the edge after `finished` → accepted.
- Reset mid-operation: assert `reset` 10 cycles into 100/7 → all outputs 0 next edge, no `finished`; a following 9/3 gives `lo`=3, `hi`=0.
- Divide by zero:
  - With `DIVIDER_ZERO_CHECK_EN`: 5/0 after a prior 9/3 → `finished` and `div_zero` at edge 1, `hi`=0, `lo`=3 held.
  - Without the macro: 5/0 → `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=0.
